// File: rtl/button_event_classifier.sv
// Turns the debounced button level and press pulse into one-cycle UI events.
// Events are short press, double click, long press and auto-repeat while held.
module button_event_classifier #(
  parameter int LONG_CYCLES   = 13_500_000,
  parameter int DCLICK_CYCLES = 6_750_000,
  parameter int REPEAT_CYCLES = 2_700_000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  input  logic btn_pulse,
  output logic evt_short,
  output logic evt_double,
  output logic evt_long,
  output logic evt_repeat,
  output logic busy
);

  localparam int MAX_LD     = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
  localparam int MAX_CYCLES = (MAX_LD > REPEAT_CYCLES) ? MAX_LD : REPEAT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES);

  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_WAIT2,
    S_WAIT_REL,
    S_HELD
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_short, r_double, r_long, r_repeat;
  logic          w_short_next, w_double_next, w_long_next, w_repeat_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_short  <= w_short_next;
      r_double <= w_double_next;
      r_long   <= w_long_next;
      r_repeat <= w_repeat_next;
    end
  end

  // Every state change clears the counter; terminal counts end a phase, so it never wraps.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_short_next  = 1'b0;
    w_double_next = 1'b0;
    w_long_next   = 1'b0;
    w_repeat_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (btn_pulse) begin
          w_state_next = S_PRESS1;
        end
      end
      S_PRESS1: begin
        if (!btn_level) begin
          w_state_next = S_WAIT2;
          w_cnt_next   = '0;
        end else if (r_cnt == LONG_LAST) begin
          w_state_next = S_HELD;
          w_cnt_next   = '0;
          w_long_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_WAIT2: begin
        // A re-press on the timeout edge still counts as a double click.
        if (btn_pulse) begin
          w_state_next  = S_WAIT_REL;
          w_cnt_next    = '0;
          w_double_next = 1'b1;
        end else if (r_cnt == DCLICK_LAST) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_short_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_WAIT_REL: begin
        w_cnt_next = '0;
        if (!btn_level) begin
          w_state_next = S_IDLE;
        end
      end
      S_HELD: begin
        if (!btn_level) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (REPEAT_EN) begin
          if (r_cnt == REPEAT_LAST) begin
            w_cnt_next    = '0;
            w_repeat_next = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign evt_short  = r_short;
  assign evt_double = r_double;
  assign evt_long   = r_long;
  assign evt_repeat = r_repeat;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_button_event_classifier.sv
// Drives a repeat-enabled and a repeat-disabled classifier with identical stimulus and
// compares every output each cycle against a timestamp-based gesture model.
module tb_button_event_classifier;

  localparam int LONG   = 20;
  localparam int DCLICK = 10;
  localparam int REPEAT = 5;

  localparam int P_IDLE  = 0;
  localparam int P_PRESS = 1;
  localparam int P_GAP   = 2;
  localparam int P_WREL  = 3;
  localparam int P_HELD  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_level = 1'b0;
  logic btn_pulse = 1'b0;
  logic [1:0] evt_short, evt_double, evt_long, evt_repeat, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int       m_phase [2];
  int       m_t0    [2];
  logic [3:0] m_evt [2];   // {repeat, long, double, short}
  int       ev_cnt  [2][4];

  button_event_classifier #(
    .LONG_CYCLES(LONG), .DCLICK_CYCLES(DCLICK), .REPEAT_CYCLES(REPEAT), .REPEAT_EN(1'b1)
  ) dut_rep (
    .clk(clk), .rst(rst), .btn_level(btn_level), .btn_pulse(btn_pulse),
    .evt_short(evt_short[0]), .evt_double(evt_double[0]), .evt_long(evt_long[0]),
    .evt_repeat(evt_repeat[0]), .busy(busy[0])
  );

  button_event_classifier #(
    .LONG_CYCLES(LONG), .DCLICK_CYCLES(DCLICK), .REPEAT_CYCLES(REPEAT), .REPEAT_EN(1'b0)
  ) dut_norep (
    .clk(clk), .rst(rst), .btn_level(btn_level), .btn_pulse(btn_pulse),
    .evt_short(evt_short[1]), .evt_double(evt_double[1]), .evt_long(evt_long[1]),
    .evt_repeat(evt_repeat[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Gesture model: each phase remembers the edge it began on; events fire on elapsed time.
  task automatic model_edge(input logic lvl, input logic pls, input logic rs);
    for (int d = 0; d < 2; d++) begin
      m_evt[d] = 4'b0000;
      if (rs) begin
        m_phase[d] = P_IDLE;
      end else begin
        case (m_phase[d])
          P_IDLE: if (pls) begin m_phase[d] = P_PRESS; m_t0[d] = cyc; end
          P_PRESS: begin
            if (!lvl) begin
              m_phase[d] = P_GAP; m_t0[d] = cyc;
            end else if (cyc - m_t0[d] == LONG) begin
              m_evt[d][2] = 1'b1; m_phase[d] = P_HELD; m_t0[d] = cyc;
            end
          end
          P_GAP: begin
            if (pls) begin
              m_evt[d][1] = 1'b1; m_phase[d] = P_WREL;
            end else if (cyc - m_t0[d] == DCLICK) begin
              m_evt[d][0] = 1'b1; m_phase[d] = P_IDLE;
            end
          end
          P_WREL: if (!lvl) m_phase[d] = P_IDLE;
          P_HELD: begin
            if (!lvl) m_phase[d] = P_IDLE;
            else if (d == 0 && ((cyc - m_t0[d]) % REPEAT) == 0) m_evt[d][3] = 1'b1;
          end
          default: m_phase[d] = P_IDLE;
        endcase
      end
    end
  endtask

  task automatic step(input logic lvl, input logic pls, input logic rs);
    logic [3:0] obs;
    @(negedge clk);
    btn_level = lvl;
    btn_pulse = pls;
    rst       = rs;
    @(posedge clk);
    cyc++;
    model_edge(lvl, pls, rs);
    #1;
    for (int d = 0; d < 2; d++) begin
      obs = {evt_repeat[d], evt_long[d], evt_double[d], evt_short[d]};
      check($sformatf("short[%0d]@%0d", d, cyc),  32'(obs[0]), 32'(m_evt[d][0]));
      check($sformatf("double[%0d]@%0d", d, cyc), 32'(obs[1]), 32'(m_evt[d][1]));
      check($sformatf("long[%0d]@%0d", d, cyc),   32'(obs[2]), 32'(m_evt[d][2]));
      check($sformatf("repeat[%0d]@%0d", d, cyc), 32'(obs[3]), 32'(m_evt[d][3]));
      check($sformatf("busy[%0d]@%0d", d, cyc),   32'(busy[d]), 32'(m_phase[d] != P_IDLE));
      check($sformatf("onehot[%0d]@%0d", d, cyc), 32'($onehot0(obs)), 32'd1);
      for (int e = 0; e < 4; e++) ev_cnt[d][e] += int'(obs[e]);
    end
  endtask

  task automatic press(input int hold);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 1; i < hold; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic release_for(input int low);
    for (int i = 0; i < low; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++)
      for (int e = 0; e < 4; e++) ev_cnt[d][e] = 0;
  endtask

  task automatic expect_counts(input string name, input int d,
                               input int s, input int db, input int l, input int r);
    check({name, "_nshort"},  ev_cnt[d][0], s);
    check({name, "_ndouble"}, ev_cnt[d][1], db);
    check({name, "_nlong"},   ev_cnt[d][2], l);
    check({name, "_nrepeat"}, ev_cnt[d][3], r);
    $display("[TB] %s dut%0d events s=%0d d=%0d l=%0d r=%0d", name, d,
             ev_cnt[d][0], ev_cnt[d][1], ev_cnt[d][2], ev_cnt[d][3]);
  endtask

  initial begin
    int hold, gap;
    for (int d = 0; d < 2; d++) begin m_phase[d] = P_IDLE; m_t0[d] = 0; end
    clear_counts();

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    // Level without a pulse must not start a gesture.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    release_for(3);

    clear_counts(); press(5); release_for(15);
    expect_counts("short", 0, 1, 0, 0, 0);
    expect_counts("short", 1, 1, 0, 0, 0);

    clear_counts(); press(3); release_for(4); press(3); release_for(15);
    expect_counts("double", 0, 0, 1, 0, 0);

    clear_counts(); press(32); release_for(10);
    expect_counts("hold32", 0, 0, 0, 1, 2);
    expect_counts("hold32", 1, 0, 0, 1, 0);

    // Ten low cycles put the re-press exactly on the timeout edge.
    clear_counts(); press(3); release_for(DCLICK); press(3); release_for(15);
    expect_counts("edge", 0, 0, 1, 0, 0);
    expect_counts("edge", 1, 0, 1, 0, 0);

    clear_counts(); press(3); release_for(DCLICK + 1); press(3); release_for(15);
    expect_counts("late", 0, 2, 0, 0, 0);

    clear_counts(); press(15);
    step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
    release_for(5);
    expect_counts("rst", 0, 0, 0, 0, 0);
    press(5); release_for(15);
    expect_counts("rst_after", 0, 1, 0, 0, 0);

    clear_counts(); press(40); release_for(10);
    expect_counts("hold40", 0, 0, 0, 1, 3);
    expect_counts("hold40", 1, 0, 0, 1, 0);

    for (int g = 0; g < 200; g++) begin
      hold = int'($urandom_range(1, 45));
      gap  = int'($urandom_range(1, 14));
      $display("[TB] gesture %0d hold=%0d gap=%0d", g, hold, gap);
      press(hold);
      if ($urandom_range(0, 19) == 0) begin
        step(btn_level, 1'b0, 1'b1);
      end
      release_for(gap);
    end
    release_for(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
